// File: rtl/spi_frame_decoder_if.sv
// Register-bus bundle between spi_frame_decoder and the register file.
// master drives address/data/strobes; slave returns read data one cycle after reg_re.
interface spi_frame_decoder_if;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/spi_frame_decoder.sv
// SPI command-frame decoder: CMD={rw,addr}, write CMD,DATA[,CRC], read CMD,DUMMY.
// Define SPI_FRAME_CRC_EN to add the trailing CRC-8 byte on writes plus crc_err/err_cnt.
module spi_frame_decoder (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ss,
  input  logic                       rx_strobe,
  input  logic [7:0]                 rx_data,
  input  logic                       tx_strobe,
  output logic [7:0]                 tx_data,
  spi_frame_decoder_if.master        bus,
  output logic                       crc_err,
  output logic [7:0]                 err_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WDATA   = 3'd1,
`ifdef SPI_FRAME_CRC_EN
    WCRC    = 3'd2,
`endif
    RDUMMY  = 3'd3,
    DISCARD = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [6:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       rvld_q, rvld_d;
  logic [7:0] tx_q, tx_d;
  logic       rx_ok;

`ifdef SPI_FRAME_CRC_EN
  logic [7:0] crc_q, crc_d;
  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;

  // CRC-8, poly 0x07, MSB first, one byte per call
  function automatic logic [7:0] crc8(
    input logic [7:0] c,
    input logic [7:0] b
  );
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction
`endif

  assign rx_ok = rx_strobe & ~ss;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    rvld_d  = re_q;
    tx_d    = tx_q;
`ifdef SPI_FRAME_CRC_EN
    crc_d   = crc_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
`endif

    if (tx_strobe && !ss) begin
      tx_d = 8'h00;
    end

    unique case (state_q)
      IDLE: begin
        if (rx_ok) begin
          addr_d = rx_data[6:0];
`ifdef SPI_FRAME_CRC_EN
          crc_d  = crc8(8'h00, rx_data);
`endif
          if (rx_data[7]) begin
            state_d = WDATA;
          end else begin
            re_d    = 1'b1;
            state_d = RDUMMY;
          end
        end
      end
      WDATA: begin
        if (rx_ok) begin
          wdata_d = rx_data;
`ifdef SPI_FRAME_CRC_EN
          crc_d   = crc8(crc_q, rx_data);
          state_d = WCRC;
`else
          we_d    = 1'b1;
          state_d = DISCARD;
`endif
        end
      end
`ifdef SPI_FRAME_CRC_EN
      WCRC: begin
        if (rx_ok) begin
          if (rx_data == crc_q) begin
            we_d = 1'b1;
          end else begin
            err_d = 1'b1;
            cnt_d = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
          end
          state_d = DISCARD;
        end
      end
`endif
      RDUMMY: begin
        // read data arrives the cycle after reg_re; load overrides a clear
        if (rvld_q) begin
          tx_d = bus.reg_rdata;
        end
        if (rx_ok) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        state_d = DISCARD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (ss) begin
      state_d = IDLE;
      tx_d    = 8'h00;
      we_d    = 1'b0;
      re_d    = 1'b0;
      rvld_d  = 1'b0;
`ifdef SPI_FRAME_CRC_EN
      crc_d   = 8'h00;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= 7'h00;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      rvld_q  <= 1'b0;
      tx_q    <= 8'h00;
`ifdef SPI_FRAME_CRC_EN
      crc_q   <= 8'h00;
      err_q   <= 1'b0;
      cnt_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      rvld_q  <= rvld_d;
      tx_q    <= tx_d;
`ifdef SPI_FRAME_CRC_EN
      crc_q   <= crc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bus.reg_addr  = addr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.reg_we    = we_q;
  assign bus.reg_re    = re_q;
  assign tx_data       = tx_q;

`ifdef SPI_FRAME_CRC_EN
  assign crc_err = err_q;
  assign err_cnt = cnt_q;
`else
  assign crc_err = 1'b0;
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_spi_frame_decoder.sv
// Self-checking bench for spi_frame_decoder; expected bus ops queued, popped by monitor.
// Adapts to SPI_FRAME_CRC_EN being defined or not.
module tb_spi_frame_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ss = 1'b1;
  logic       rx_strobe = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_strobe = 1'b0;
  logic [7:0] tx_data;
  logic       crc_err;
  logic [7:0] err_cnt;

  spi_frame_decoder_if bus();

  spi_frame_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .ss        (ss),
    .rx_strobe (rx_strobe),
    .rx_data   (rx_data),
    .tx_strobe (tx_strobe),
    .tx_data   (tx_data),
    .bus       (bus),
    .crc_err   (crc_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       we;
    bit [6:0] addr;
    bit [7:0] data;
  } op_t;

  op_t        exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         crc_err_seen = 0;
  int         exp_crc_err = 0;
  logic [7:0] mem [0:127];

  // register-file model: read data valid one cycle after reg_re
  always @(posedge clk) begin
    bus.reg_rdata <= bus.reg_re ? mem[bus.reg_addr] : 8'h00;
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      if (bus.reg_we && bus.reg_re) begin
        n_cmp++;
        n_err++;
        $display("FAIL we_re_both got we=1 re=1 want exclusive");
      end
      if (bus.reg_we || bus.reg_re) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_op got we=%b re=%b addr=%h want none",
                   bus.reg_we, bus.reg_re, bus.reg_addr);
        end else begin
          op_t e;
          e = exp_q.pop_front();
          if (e.we !== bus.reg_we || e.addr !== bus.reg_addr ||
              (e.we && e.data !== bus.reg_wdata)) begin
            n_err++;
            $display("FAIL bus_op got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                     bus.reg_we, bus.reg_addr, bus.reg_wdata, e.we, e.addr, e.data);
          end
        end
      end
      if (crc_err) crc_err_seen++;
    end
  end

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] r;
    r = c ^ b;
    for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data   = b;
    rx_strobe = 1'b1;
    @(negedge clk);
    rx_strobe = 1'b0;
  endtask

  task automatic open_frame();
    ss = 1'b0;
    tick(1);
  endtask

  task automatic close_frame();
    ss = 1'b1;
    tick(2);
  endtask

  task automatic push(input bit we, input logic [6:0] a, input logic [7:0] d);
    op_t o;
    o.we = we; o.addr = a; o.data = d;
    exp_q.push_back(o);
  endtask

  task automatic write_frame(input logic [6:0] a, input logic [7:0] d);
    open_frame();
    push(1'b1, a, d);
    send({1'b1, a});
    send(d);
`ifdef SPI_FRAME_CRC_EN
    send(crc8(crc8(8'h00, {1'b1, a}), d));
`endif
    close_frame();
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain got %0d pending want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(2);
    n_cmp++;
    if ({tx_data, bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_re, crc_err, err_cnt}
        !== 34'h0) begin
      n_err++;
      $display("FAIL reset_outputs got tx=%h addr=%h wd=%h we=%b re=%b ce=%b ec=%h want 0",
               tx_data, bus.reg_addr, bus.reg_wdata, bus.reg_we, bus.reg_re, crc_err, err_cnt);
    end
    rst = 1'b1;
    tick(1);
    // abort mid-frame by reset
    open_frame();
    send(8'h81);
`ifdef SPI_FRAME_CRC_EN
    send(8'h55);
`endif
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.reg_addr !== 7'h00 || bus.reg_we !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset got addr=%h we=%b want 00 0", bus.reg_addr, bus.reg_we);
    end
    @(negedge clk);
    rst = 1'b1;
    close_frame();
    tick(2);
    check_drained("reset");
  endtask

  task automatic test_write();
    open_frame();
`ifdef SPI_FRAME_CRC_EN
    push(1'b1, 7'h00, 8'h00);
    send(8'h80);
    send(8'h00);
    n_cmp++;
    if (bus.reg_we !== 1'b0) begin
      n_err++; $display("FAIL early_we got %b want 0", bus.reg_we);
    end
    send(8'hB6);
    n_cmp++;
    if (bus.reg_we !== 1'b1 || bus.reg_addr !== 7'h00 ||
        bus.reg_wdata !== 8'h00 || crc_err !== 1'b0) begin
      n_err++;
      $display("FAIL write_crc got we=%b addr=%h wd=%h ce=%b want 1 00 00 0",
               bus.reg_we, bus.reg_addr, bus.reg_wdata, crc_err);
    end
`else
    push(1'b1, 7'h02, 8'hA5);
    send(8'h82);
    n_cmp++;
    if (bus.reg_we !== 1'b0) begin
      n_err++; $display("FAIL early_we got %b want 0", bus.reg_we);
    end
    send(8'hA5);
    n_cmp++;
    if (bus.reg_we !== 1'b1 || bus.reg_addr !== 7'h02 || bus.reg_wdata !== 8'hA5) begin
      n_err++;
      $display("FAIL write_nocrc got we=%b addr=%h wd=%h want 1 02 a5",
               bus.reg_we, bus.reg_addr, bus.reg_wdata);
    end
`endif
    tick(1);
    n_cmp++;
    if (bus.reg_we !== 1'b0) begin
      n_err++; $display("FAIL we_pulse got %b want 0", bus.reg_we);
    end
    close_frame();
    for (int i = 0; i < 6; i++) begin
      write_frame(7'($urandom_range(0, 127)), 8'($urandom));
    end
    check_drained("write");
    n_cmp++;
    if (crc_err_seen != exp_crc_err) begin
      n_err++;
      $display("FAIL write_no_crc_err got %0d want %0d", crc_err_seen, exp_crc_err);
    end
  endtask

  task automatic test_crc_error();
`ifdef SPI_FRAME_CRC_EN
    logic [7:0] exp_cnt;
    logic [7:0] c;
    logic [6:0] a;
    logic [7:0] d;
    open_frame();
    send(8'h80);
    send(8'h00);
    send(8'hB7);
    exp_crc_err++;
    exp_cnt = 8'h01;
    n_cmp++;
    if (crc_err !== 1'b1 || bus.reg_we !== 1'b0 || err_cnt !== exp_cnt) begin
      n_err++;
      $display("FAIL crc_bad got ce=%b we=%b ec=%h want 1 0 %h",
               crc_err, bus.reg_we, err_cnt, exp_cnt);
    end
    tick(1);
    n_cmp++;
    if (crc_err !== 1'b0) begin
      n_err++; $display("FAIL crc_err_pulse got %b want 0", crc_err);
    end
    close_frame();
    n_cmp++;
    if (err_cnt !== exp_cnt) begin
      n_err++; $display("FAIL err_cnt_kept got %h want %h", err_cnt, exp_cnt);
    end
    for (int i = 0; i < 256; i++) begin
      a = 7'($urandom_range(0, 127));
      d = 8'($urandom);
      c = crc8(crc8(8'h00, {1'b1, a}), d) ^ 8'($urandom_range(1, 255));
      open_frame();
      send({1'b1, a});
      send(d);
      send(c);
      exp_crc_err++;
      exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
      close_frame();
    end
    n_cmp++;
    if (err_cnt !== exp_cnt || err_cnt !== 8'hFF) begin
      n_err++; $display("FAIL err_cnt_sat got %h want %h", err_cnt, exp_cnt);
    end
    n_cmp++;
    if (crc_err_seen != exp_crc_err) begin
      n_err++; $display("FAIL crc_err_count got %0d want %0d", crc_err_seen, exp_crc_err);
    end
`else
    open_frame();
    push(1'b1, 7'h00, 8'h00);
    send(8'h80);
    send(8'h00);
    send(8'hB7);
    n_cmp++;
    if (crc_err !== 1'b0 || err_cnt !== 8'h00) begin
      n_err++; $display("FAIL crc_tied got ce=%b ec=%h want 0 00", crc_err, err_cnt);
    end
    close_frame();
`endif
    check_drained("crc");
  endtask

  task automatic test_read();
    logic [6:0] a;
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 7'h15 : 7'($urandom_range(0, 127));
      v = (i == 0) ? 8'h3C : 8'($urandom_range(1, 255));
      mem[a] = v;
      open_frame();
      push(1'b0, a, 8'h00);
      send({1'b0, a});
      n_cmp++;
      if (bus.reg_re !== 1'b1 || bus.reg_addr !== a || tx_data !== 8'h00) begin
        n_err++;
        $display("FAIL read_re got re=%b addr=%h tx=%h want 1 %h 00",
                 bus.reg_re, bus.reg_addr, tx_data, a);
      end
      tick(1);
      n_cmp++;
      if (tx_data !== 8'h00 || bus.reg_re !== 1'b0) begin
        n_err++; $display("FAIL read_early got tx=%h re=%b want 00 0", tx_data, bus.reg_re);
      end
      tick(1);
      n_cmp++;
      if (tx_data !== v) begin
        n_err++; $display("FAIL read_tx got %h want %h", tx_data, v);
      end
      tick(1);
      n_cmp++;
      if (tx_data !== v) begin
        n_err++; $display("FAIL read_hold got %h want %h", tx_data, v);
      end
      tx_strobe = 1'b1;
      tick(1);
      tx_strobe = 1'b0;
      n_cmp++;
      if (tx_data !== 8'h00) begin
        n_err++; $display("FAIL read_clear got %h want 00", tx_data);
      end
      send(8'hFF);
      close_frame();
    end
    check_drained("read");
  endtask

  task automatic test_abort();
    open_frame();
    send(8'h81);
`ifdef SPI_FRAME_CRC_EN
    send(8'h55);
`endif
    close_frame();
    n_cmp++;
    if (tx_data !== 8'h00 || bus.reg_we !== 1'b0) begin
      n_err++; $display("FAIL abort got tx=%h we=%b want 00 0", tx_data, bus.reg_we);
    end
    write_frame(7'h03, 8'h66);
    check_drained("abort");
  endtask

  task automatic test_extra();
    logic [7:0] c;
    logic [7:0] s [9];
    c = 8'h00;
    for (int i = 0; i < 9; i++) s[i] = 8'h31 + 8'(i);
    for (int i = 0; i < 9; i++) c = crc8(c, s[i]);
    n_cmp++;
    if (c !== 8'hF4) begin
      n_err++; $display("FAIL crc_model got %h want f4", c);
    end
    // complete write, then trailing bytes and tx strobes
    open_frame();
    push(1'b1, 7'h07, 8'h11);
    send(8'h87);
    send(8'h11);
`ifdef SPI_FRAME_CRC_EN
    send(crc8(crc8(8'h00, 8'h87), 8'h11));
`endif
    send(8'h82);
    send(8'h05);
    tx_strobe = 1'b1;
    tick(1);
    tx_strobe = 1'b0;
    send(8'h00);
    n_cmp++;
    if (tx_data !== 8'h00) begin
      n_err++; $display("FAIL extra_tx got %h want 00", tx_data);
    end
    close_frame();
    // complete read, then trailing bytes
    open_frame();
    push(1'b0, 7'h20, 8'h00);
    send(8'h20);
    tick(3);
    send(8'h00);
    send(8'h21);
    send(8'hA2);
    close_frame();
    // strobe while deselected, and strobe coincident with ss rising
    ss = 1'b1;
    send(8'h05);
    ss = 1'b0;
    tick(1);
    send(8'h84);
`ifdef SPI_FRAME_CRC_EN
    send(8'h9A);
    c = crc8(crc8(8'h00, 8'h84), 8'h9A);
`else
    c = 8'h9A;
`endif
    ss = 1'b1;
    send(c);
    tick(2);
    write_frame(7'h04, 8'h9A);
    check_drained("extra");
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    test_reset();
    test_write();
    test_crc_error();
    test_read();
    test_abort();
    test_extra();
    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_frame_decoder.md
SPI_FRAME_DECODER -- requirements
Module: spi_frame_decoder

Interface
REQ-001 SHALL have ports clk (in, 1, system clock, all logic on rising edge) and rst (in, 1, reset), where reset is asynchronous and active-low.
REQ-002 SHALL have port ss (in, 1): SPI slave-select, already synchronised to clk; 1 = deselected.
REQ-003 SHALL have ports rx_strobe (in, 1, one-cycle pulse, received byte complete) and rx_data (in, 8, received byte, valid while rx_strobe=1).
REQ-004 SHALL have ports tx_strobe (in, 1, one-cycle pulse, SPI slave loaded tx_data) and tx_data (out, 8, next byte to shift out).
REQ-005 SHALL have register-bus ports: reg_addr (out, 7), reg_wdata (out, 8), reg_we (out, 1, pulse), reg_re (out, 1, pulse) and reg_rdata (in, 8, valid exactly 1 cycle after reg_re).
REQ-006 SHALL have status ports crc_err (out, 1, pulse) and err_cnt (out, 8, saturating CRC-error count).

Function
REQ-007 SHALL decode frames of the form CMD = {rw, addr[6:0]}, where rw=1 is write and rw=0 is read.
REQ-008 SHALL use write frame CMD, DATA[, CRC] and read frame CMD, DUMMY.
REQ-009 SHALL implement states IDLE, WDATA, WCRC, RDUMMY and DISCARD; reset state is IDLE.
REQ-010 IDLE, on rx_strobe: SHALL latch reg_addr = rx_data[6:0]; rw=1 goes to WDATA; rw=0 pulses reg_re in the next cycle and goes to RDUMMY.
REQ-011 RDUMMY: SHALL load tx_data = reg_rdata one cycle after reg_re, i.e. 2 cycles after the CMD rx_strobe.
REQ-012 RDUMMY: on the next tx_strobe, tx_data SHALL return to 0x00; on rx_strobe (dummy byte) SHALL go to DISCARD.
REQ-013 WDATA, on rx_strobe: SHALL latch reg_wdata = rx_data and go to WCRC (CRC enabled) or pulse reg_we 1 cycle later and go to DISCARD (CRC disabled).
REQ-014 WCRC, on rx_strobe: SHALL compare rx_data with the running CRC over CMD and DATA.
REQ-015 WCRC match: SHALL pulse reg_we 1 cycle later; mismatch: SHALL pulse crc_err 1 cycle later, increment err_cnt saturating at 0xFF, and assert no reg_we. Both cases go to DISCARD.
REQ-016 DISCARD: SHALL ignore all further rx_strobe and tx_strobe events until ss=1.
REQ-017 ss=1 in any state SHALL synchronously force IDLE, clear the running CRC, set tx_data=0x00 and cancel any not-yet-issued reg_we/reg_re; err_cnt SHALL be kept.
REQ-018 reg_addr/reg_wdata SHALL be stable for the cycle reg_we or reg_re is high; reg_we and reg_re SHALL never both be 1.
REQ-019 CRC SHALL be CRC-8 with poly 0x07, init 0x00, MSB-first, no reflection and xorout 0x00; it is updated in the cycle of each counted rx_strobe and reset on IDLE entry.
REQ-020 rx_strobe with ss=1 SHALL be ignored; rx_strobe and ss rising in the same cycle SHALL follow ss.
REQ-021 tx_data SHALL be 0x00 at all times except from the RDUMMY load until the following tx_strobe.

Reset
REQ-022 rst=0 SHALL asynchronously set state=IDLE, tx_data=0x00, reg_addr=0, reg_wdata=0x00, reg_we=0, reg_re=0, crc_err=0, err_cnt=0x00 and CRC=0x00.
REQ-023 Reset mid-frame SHALL abort the frame with no reg_we issued.

Configuration
REQ-024 Macro SPI_FRAME_CRC_EN defined: write frames SHALL carry the trailing CRC byte and the WCRC state, crc_err and err_cnt SHALL be active.
REQ-025 Macro SPI_FRAME_CRC_EN undefined: the WCRC state and CRC logic SHALL be absent, writes SHALL commit after DATA, and crc_err=0 and err_cnt=0x00 SHALL be tied constant.

Verification
REQ-026 Bench SHALL cover: CRC_EN, ss=0, rx 0x80, 0x00, 0xB6 -> one reg_we pulse with reg_addr=0x00, reg_wdata=0x00, crc_err=0.
REQ-027 Bench SHALL cover: CRC_EN, rx 0x80, 0x00, 0xB7 -> no reg_we, crc_err pulse, err_cnt=0x01; 256 bad frames -> err_cnt=0xFF.
REQ-028 Bench SHALL cover: rx 0x15, reg_rdata=0x3C -> reg_re pulse with reg_addr=0x15, tx_data=0x3C 2 cycles after rx_strobe, then 0x00 after next tx_strobe.
REQ-029 Bench SHALL cover: rx 0x81, 0x55, then ss=1 before the CRC byte -> no reg_we, state IDLE, next frame decodes normally.
REQ-030 Bench SHALL cover: CRC unit standalone over ASCII "123456789" -> 0xF4; extra bytes after a complete frame -> no extra reg_we or reg_re.
REQ-031 Bench SHALL cover: CRC_EN undefined, rx 0x82, 0xA5 -> reg_we with reg_addr=0x02 and reg_wdata=0xA5 one cycle after the second rx_strobe.
